// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- run-time configurable UART transmitter.
//
// Sends one frame per accepted payload: a start bit (0), 6..9 data bits
// LSB first, an optional even/odd parity bit, and 1..3 stop bits (1). All
// frame settings are captured at accept, so inputs may change freely while
// a frame is on the line. A payload offered on the last cycle of the last
// stop bit is accepted back-to-back, and the next start bit follows with no
// idle gap.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset (aborts any frame)
//   en_i           enable; gates acceptance of new frames only
//   baud_rate_i    bit period minus one, in clk_i cycles
//   data_size_i    data bits per frame (6..9; other values mean 8)
//   parity_size_i  1 = parity bit present
//   parity_type_i  0 = even, 1 = odd
//   stop_size_i    stop bits per frame (1..3; 0 means 1)
//   data_i         payload, right-justified, bit 0 sent first
//   valid_i        payload request, held until accepted
//   ready_o        a payload is accepted this cycle if valid_i is high
//   tx_o           serial line, idle high
//   busy_o         a frame is in progress
//   done_o         one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] baud_rate_i,
  input  logic [3:0]  data_size_i,
  input  logic        parity_size_i,
  input  logic        parity_type_i,
  input  logic [1:0]  stop_size_i,
  input  logic [8:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;   // cycle within the current bit
  logic [3:0]  bit_cnt_q, bit_cnt_d;     // data-bit or stop-bit index
  logic        tx_q, tx_d;

  // Frame settings captured at accept.
  logic [8:0]  data_q, data_d;
  logic [3:0]  size_q, size_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic [1:0]  stop_q, stop_d;
  logic [31:0] baud_q, baud_d;

  // Sanitised view of the live inputs, used only at the moment of accept.
  logic [3:0]  size_in;
  logic [1:0]  stop_in;
  logic [8:0]  data_mask;
  logic        par_in;

  logic        bit_end;
  logic        last_stop;
  logic        accept;

  always_comb begin
    size_in   = (data_size_i >= 4'd6 && data_size_i <= 4'd9) ? data_size_i : 4'd8;
    stop_in   = (stop_size_i == 2'd0) ? 2'd1 : stop_size_i;
    data_mask = 9'h1ff >> (4'd9 - size_in);
    par_in    = (^(data_i & data_mask)) ^ parity_type_i;
  end

  // Frame boundary decode. ready_o is forced low during reset so nothing
  // can be accepted on the same edge that clears the state.
  assign bit_end   = (baud_cnt_q == baud_q);
  assign last_stop = (state_q == S_STOP) && bit_end &&
                     (bit_cnt_q == {2'b00, stop_q - 2'd1});
  assign ready_o   = en_i & ~rst_i & ((state_q == S_IDLE) | last_stop);
  assign accept    = valid_i & ready_o;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = bit_end ? 32'd0 : baud_cnt_q + 32'd1;
    data_d     = data_q;
    size_d     = size_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_d     = stop_q;
    baud_d     = baud_q;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = 32'd0;
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == size_q - 4'd1) begin
            state_d   = par_en_q ? S_PARITY : S_STOP;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = 4'd0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d   = accept ? S_START : S_IDLE;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture is shared by the idle and back-to-back accept paths.
    if (accept) begin
      data_d     = data_i;
      size_d     = size_in;
      par_en_d   = parity_size_i;
      par_bit_d  = par_in;
      stop_d     = stop_in;
      baud_d     = baud_rate_i;
      baud_cnt_d = 32'd0;
      bit_cnt_d  = 4'd0;
    end

    // tx_o is registered: derive it from the state being entered so the
    // line changes on the same edge as the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_cnt_d];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 32'd0;
      bit_cnt_q  <= 4'd0;
      tx_q       <= 1'b1;
      data_q     <= 9'd0;
      size_q     <= 4'd8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_q     <= 2'd1;
      baud_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      size_q     <= size_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_q     <= stop_d;
      baud_q     <= baud_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = last_stop & ~rst_i;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// A frame model expands each payload into per-cycle expectations of
// {tx_o, busy_o, done_o, ready_o}, queued when the payload is driven and
// popped each cycle the DUT runs. Inputs change on the falling edge; outputs
// are sampled on the falling edge before inputs are updated.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_i, en_i, valid_i;
  logic [31:0] baud_rate_i;
  logic [3:0]  data_size_i;
  logic        parity_size_i, parity_type_i;
  logic [1:0]  stop_size_i;
  logic [8:0]  data_i;
  logic        ready_o, tx_o, busy_o, done_o;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .baud_rate_i   (baud_rate_i),
    .data_size_i   (data_size_i),
    .parity_size_i (parity_size_i),
    .parity_type_i (parity_type_i),
    .stop_size_i   (stop_size_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  typedef struct {
    logic [8:0]  data;
    logic [3:0]  dsize;
    logic        pen;
    logic        ptype;
    logic [1:0]  ssize;
    logic [31:0] baud;
    int          exp_len;   // hand-computed (1+N+P+S)*(baud+1)
  } vec_t;

  vec_t       vecs[9];
  logic [3:0] exp_q[$];     // {tx, busy, done, ready} per cycle
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {tx_o, busy_o, done_o, ready_o};
  endfunction

  // Frame model: start, N data bits LSB first, optional parity, S stop bits.
  task automatic push_frame(input vec_t v, input logic rdy_last);
    logic bits[$];
    logic par;
    int   n, s;
    logic last;
    n = (v.dsize >= 4'd6 && v.dsize <= 4'd9) ? int'(v.dsize) : 8;
    s = (v.ssize == 2'd0) ? 1 : int'(v.ssize);
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(v.data[i]);
      par ^= v.data[i];
    end
    if (v.pen) bits.push_back(par ^ v.ptype);
    for (int i = 0; i < s; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c <= int'(v.baud); c++) begin
        last = (b == bits.size() - 1) && (c == int'(v.baud));
        exp_q.push_back({bits[b], 1'b1, last, last & rdy_last});
      end
    end
  endtask

  task automatic drive(input vec_t v);
    data_i        = v.data;
    data_size_i   = v.dsize;
    parity_size_i = v.pen;
    parity_type_i = v.ptype;
    stop_size_i   = v.ssize;
    baud_rate_i   = v.baud;
  endtask

  // Garbage on the config/payload inputs mid-frame must not matter.
  task automatic scramble();
    data_i        = 9'($urandom);
    data_size_i   = 4'($urandom);
    parity_size_i = 1'($urandom);
    parity_type_i = 1'($urandom);
    stop_size_i   = 2'($urandom);
    baud_rate_i   = 32'($urandom_range(0, 7));
  endtask

  task automatic cmp_cycle(input string tag, output logic [3:0] e);
    e = exp_q.pop_front();
    check(tag, 32'(outs()), 32'(e));
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [3:0] e;
    int len, cyc;
    @(negedge clk);
    en_i = 1'b1;
    drive(v);
    valid_i = 1'b1;
    push_frame(v, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    scramble();
    len = 0;
    cyc = 1;
    while (exp_q.size() > 0) begin
      if (busy_o) len++;
      cmp_cycle($sformatf("vec%0d cycle%0d {tx,busy,done,ready}", idx, cyc), e);
      cyc++;
      @(negedge clk);
    end
    check($sformatf("vec%0d frame length", idx), 32'(len), 32'(v.exp_len));
    check($sformatf("vec%0d idle after frame", idx), 32'(outs()), 32'(4'b1001));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    logic [8:0] b2b_data[3];
    vec_t       b2b;
    int         p, gap, dones, cyc;

    //          data    dsize pen ptype ssize baud  len
    vecs[0] = '{9'h0A5, 4'd8,  0,  0,  2'd1, 32'd3, 40};  // 8N1
    vecs[1] = '{9'h041, 4'd7,  1,  0,  2'd1, 32'd0, 10};  // 7E1
    vecs[2] = '{9'h041, 4'd7,  1,  1,  2'd1, 32'd0, 10};  // 7O1
    vecs[3] = '{9'h1FF, 4'd9,  0,  0,  2'd2, 32'd1, 24};  // 9N2
    vecs[4] = '{9'h13C, 4'd3,  1,  0,  2'd1, 32'd2, 33};  // size 3 -> 8
    vecs[5] = '{9'h0C3, 4'd15, 0,  0,  2'd0, 32'd0, 10};  // size 15 -> 8, stop 0 -> 1
    vecs[6] = '{9'h1EB, 4'd6,  1,  1,  2'd3, 32'd1, 22};  // 6O3, upper bits ignored
    vecs[7] = '{9'h155, 4'd9,  1,  1,  2'd1, 32'd4, 60};  // 9O1
    vecs[8] = '{9'h03F, 4'd6,  0,  0,  2'd2, 32'd0, 9};   // 6N2

    rst_i   = 1'b1;
    en_i    = 1'b1;
    valid_i = 1'b0;
    drive(vecs[0]);

    // Reset state, with enable and a pending payload-free bus.
    repeat (3) begin
      @(negedge clk);
      check("reset {tx,busy,done,ready}", 32'(outs()), 32'(4'b1000));
    end
    rst_i = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'(outs()), 32'(4'b1001));

    // Table-driven single frames.
    for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

    // Disabled: a held request is never accepted.
    en_i    = 1'b0;
    valid_i = 1'b1;
    drive(vecs[0]);
    repeat (8) begin
      @(negedge clk);
      check("disabled no accept", 32'(outs()), 32'(4'b1000));
    end

    // Enable for one edge, then drop it: the frame completes, nothing follows.
    en_i = 1'b1;
    drive(vecs[1]);
    push_frame(vecs[1], 1'b0);
    @(negedge clk);
    en_i = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0) begin
      cmp_cycle($sformatf("en drop cycle%0d", cyc), e);
      cyc++;
      @(negedge clk);
    end
    repeat (5) begin
      check("en drop no re-accept", 32'(outs()), 32'(4'b1000));
      @(negedge clk);
    end
    valid_i = 1'b0;

    // Back-to-back 8N1 at one cycle per bit: three frames, no idle gap.
    b2b_data = '{9'h0A5, 9'h05A, 9'h1C3};
    b2b = '{9'h000, 4'd8, 0, 0, 2'd1, 32'd0, 10};
    for (int i = 0; i < 3; i++) begin
      b2b.data = b2b_data[i];
      push_frame(b2b, 1'b1);
    end
    b2b.data = b2b_data[0];
    en_i = 1'b1;
    drive(b2b);
    valid_i = 1'b1;
    p = 1; gap = 0; dones = 0; cyc = 1;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      if (!busy_o) gap++;
      if (done_o) dones++;
      cmp_cycle($sformatf("b2b cycle%0d", cyc), e);
      cyc++;
      if (e[0]) begin
        if (p < 3) data_i = b2b_data[p];
        else       valid_i = 1'b0;
        p++;
      end
      @(negedge clk);
    end
    check("b2b idle gaps", 32'(gap), 32'd0);
    check("b2b done pulses", 32'(dones), 32'd3);
    check("b2b idle after", 32'(outs()), 32'(4'b1001));

    // Reset on the fifth cycle of DATA (frame cycle 9 at four cycles per bit).
    @(negedge clk);
    drive(vecs[0]);
    valid_i = 1'b1;
    push_frame(vecs[0], 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      cmp_cycle($sformatf("pre-reset cycle%0d", c), e);
      if (c < 9) @(negedge clk);
    end
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid-frame reset", 32'(outs()), 32'(4'b1000));
    rst_i = 1'b0;
    @(negedge clk);
    check("idle after mid-frame reset", 32'(outs()), 32'(4'b1001));
    run_frame(vecs[0], 90);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
